// File: rtl/conv_window_gen.sv
// Streaming K x K sliding-window generator over a raster-order N x N image.
// Keeps K-1 previous rows in line buffers and emits one window per valid position.
module conv_window_gen #(
    parameter int DATA_WIDTH  = 16,
    parameter int KERNEL_SIZE = 5,
    parameter int IMAGE_SIZE  = 28
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       pix_valid,
    output logic                                       pix_ready,
    input  logic [DATA_WIDTH-1:0]                      pix_data,
    output logic                                       win_valid,
    input  logic                                       win_ready,
    output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] win_data,
    output logic [$clog2(IMAGE_SIZE)-1:0]              win_row,
    output logic [$clog2(IMAGE_SIZE)-1:0]              win_col,
    output logic                                       frame_done
);
    localparam int K  = KERNEL_SIZE;
    localparam int N  = IMAGE_SIZE;
    localparam int DW = DATA_WIDTH;
    localparam int CW = $clog2(IMAGE_SIZE);
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    localparam logic [CW-1:0] KM1  = CW'(K - 1);

    // Handshake: a pixel moves on an edge with pix_valid && pix_ready, a window
    // moves on an edge with win_valid && win_ready; pix_ready only drops while
    // a finished window is waiting for the consumer.
    logic [CW-1:0] row_q, row_d, col_q, col_d;
    logic [CW-1:0] win_row_q, win_row_d, win_col_q, win_col_d;
    logic          win_valid_q, win_valid_d;
    logic          frame_done_q, frame_done_d;
    logic [DW-1:0] linebuf_q [K-1][N];
    logic [DW-1:0] win_q [K][K];
    logic [DW-1:0] win_d [K][K];
    logic [DW-1:0] new_col [K];
    logic          accept, consume, completes;

    assign pix_ready = !win_valid_q || win_ready;
    assign accept    = pix_valid && pix_ready;
    assign consume   = win_valid_q && win_ready;
    assign completes = (row_q >= KM1) && (col_q >= KM1);

    // Column entering the window: oldest buffered row on top, live pixel at the bottom.
    always_comb begin
        for (int r = 0; r < K - 1; r++) begin
            new_col[r] = linebuf_q[K-2-r][col_q];
        end
        new_col[K-1] = pix_data;
    end

    always_comb begin
        row_d        = row_q;
        col_d        = col_q;
        win_row_d    = win_row_q;
        win_col_d    = win_col_q;
        win_valid_d  = win_valid_q;
        frame_done_d = frame_done_q;
        win_d        = win_q;
        if (accept) begin
            if (col_q == LAST) begin
                col_d = '0;
                row_d = (row_q == LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
                win_d[r][K-1] = new_col[r];
            end
            win_valid_d  = completes;
            frame_done_d = completes && (row_q == LAST) && (col_q == LAST);
            if (completes) begin
                win_row_d = row_q - KM1;
                win_col_d = col_q - KM1;
            end
        end else if (consume) begin
            win_valid_d  = 1'b0;
            frame_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row_q        <= '0;
            col_q        <= '0;
            win_row_q    <= '0;
            win_col_q    <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            row_q        <= row_d;
            col_q        <= col_d;
            win_row_q    <= win_row_d;
            win_col_q    <= win_col_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
            win_q        <= win_d;
        end
    end

    // Line buffers carry no reset; stale contents are never emitted because
    // windows are only produced once K rows of the current frame are present.
    always_ff @(posedge clk) begin
        if (accept) begin
            linebuf_q[0][col_q] <= pix_data;
            for (int i = 1; i < K - 1; i++) begin
                linebuf_q[i][col_q] <= linebuf_q[i-1][col_q];
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                win_data[(r*K+c)*DW +: DW] = win_q[r][c];
            end
        end
    end

    assign win_valid  = win_valid_q;
    assign win_row    = win_row_q;
    assign win_col    = win_col_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: directed frames with a reference image model and an
// expected-window queue compared on every consumed window.
module tb_conv_window_gen;
    localparam int DW = 16;
    localparam int K  = 5;
    localparam int N  = 28;
    localparam int CW = $clog2(N);
    localparam int KK = K * K;
    localparam int W  = KK * DW + 2 * CW + 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              pix_valid;
    logic              pix_ready;
    logic [DW-1:0]     pix_data;
    logic              win_valid;
    logic              win_ready;
    logic [KK*DW-1:0]  win_data;
    logic [CW-1:0]     win_row;
    logic [CW-1:0]     win_col;
    logic              frame_done;

    always #5 clk = ~clk;

    conv_window_gen #(.DATA_WIDTH(DW), .KERNEL_SIZE(K), .IMAGE_SIZE(N)) dut (
        .clk(clk), .reset(reset),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
        .win_row(win_row), .win_col(win_col), .frame_done(frame_done)
    );

    logic [W-1:0]  exp_q[$];
    int            n_assert = 0;
    int            n_fail   = 0;
    logic [DW-1:0] img [N][N];
    int            m_row, m_col;
    int            acc_cnt, win_cnt, fd_cnt, first_acc;
    bit            first_seen, stalled_prev;
    logic [W-1:0]  prev_obs;
    logic [DW-1:0] first_e00, last_fd_e00;
    bit            acc;

    function automatic logic [W-1:0] obs();
        return {frame_done, win_row, win_col, win_data};
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: store the pixel in a full image and cut the window straight out of it.
    task automatic model_accept(input logic [DW-1:0] d);
        logic [KK*DW-1:0] wd;
        logic             fd;
        wd = '0;
        img[m_row][m_col] = d;
        acc_cnt++;
        if (m_row >= K - 1 && m_col >= K - 1) begin
            for (int wr = 0; wr < K; wr++)
                for (int wc = 0; wc < K; wc++)
                    wd[(wr*K+wc)*DW +: DW] = img[m_row-K+1+wr][m_col-K+1+wc];
            fd = (m_row == N - 1 && m_col == N - 1);
            exp_q.push_back({fd, CW'(m_row - K + 1), CW'(m_col - K + 1), wd});
        end
        if (m_col == N - 1) begin
            m_col = 0;
            m_row = (m_row == N - 1) ? 0 : m_row + 1;
        end else begin
            m_col++;
        end
    endtask

    task automatic check_outputs();
        logic [W-1:0] e;
        chk("pix_ready", W'(pix_ready), W'(!(win_valid && !win_ready)));
        if (stalled_prev) chk("stall_stable", obs(), prev_obs);
        if (win_valid && win_ready) begin
            if (!first_seen) begin
                first_seen = 1;
                first_acc  = acc_cnt;
                first_e00  = win_data[DW-1:0];
            end
            chk("window_expected", W'(exp_q.size() != 0), W'(1));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("window", obs(), e);
            end
            win_cnt++;
            if (frame_done) begin
                fd_cnt++;
                last_fd_e00 = win_data[DW-1:0];
            end
        end
        stalled_prev = win_valid && !win_ready;
        prev_obs     = obs();
    endtask

    task automatic cycle(input logic v, input logic [DW-1:0] d, input logic rdy, output bit a);
        pix_valid = v;
        pix_data  = d;
        win_ready = rdy;
        @(negedge clk);
        check_outputs();
        a = v && pix_ready;
        if (a) model_accept(d);
        @(posedge clk);
        #1;
    endtask

    task automatic send_pixels(input int count, input int base, input bit neg,
                               input int gap_pct, input int stall_pct);
        int            idx;
        logic [DW-1:0] p;
        bit            a;
        for (int i = 0; i < count; i++) begin
            idx = m_row * N + m_col;
            p   = neg ? DW'(-idx - 1) : DW'(base + idx);
            a   = 0;
            for (int t = 0; t < 200 && !a; t++) begin
                cycle(logic'($urandom_range(99) >= gap_pct), p,
                      logic'($urandom_range(99) >= stall_pct), a);
            end
            if (!a) begin
                chk("accept_timeout", W'(a), W'(1));
                return;
            end
        end
        pix_valid = 1'b0;
    endtask

    task automatic drain();
        bit a;
        for (int t = 0; t < 3000 && (exp_q.size() != 0 || win_valid); t++) cycle(1'b0, '0, 1'b1, a);
        chk("drain_queue_empty", W'(exp_q.size()), W'(0));
        chk("drain_win_valid", W'(win_valid), W'(0));
    endtask

    task automatic start_frame();
        win_cnt = 0; fd_cnt = 0; acc_cnt = 0; first_seen = 0; first_acc = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; pix_valid = 1'b0; pix_data = '0; win_ready = 1'b0;
        m_row = 0; m_col = 0; stalled_prev = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_win_valid", W'(win_valid), W'(0));
        chk("reset_win_data", W'(win_data), W'(0));
        chk("reset_win_row", W'(win_row), W'(0));
        chk("reset_win_col", W'(win_col), W'(0));
        chk("reset_frame_done", W'(frame_done), W'(0));
        chk("reset_pix_ready", W'(pix_ready), W'(1));
        @(posedge clk); #1;
        reset = 1'b0;

        // Gapless ramp, always-ready consumer.
        start_frame();
        send_pixels(N * N, 0, 0, 0, 0);
        drain();
        chk("t1_first_latency", W'(first_acc), W'(117));
        chk("t1_first_e00", W'(first_e00), W'(0));
        chk("t1_win_count", W'(win_cnt), W'(576));
        chk("t1_fd_count", W'(fd_cnt), W'(1));
        chk("t1_last_e00", W'(last_fd_e00), W'(667));

        // Back-pressure from the consumer.
        start_frame();
        send_pixels(N * N, 0, 0, 0, 40);
        drain();
        chk("t2_win_count", W'(win_cnt), W'(576));
        chk("t2_fd_count", W'(fd_cnt), W'(1));

        // Source gaps.
        start_frame();
        send_pixels(N * N, 0, 0, 50, 0);
        drain();
        chk("t3_win_count", W'(win_cnt), W'(576));
        chk("t3_last_e00", W'(last_fd_e00), W'(667));

        // Two frames back-to-back, second offset by 1000.
        start_frame();
        send_pixels(N * N, 0, 0, 0, 0);
        send_pixels(N * N, 1000, 0, 20, 20);
        drain();
        chk("t4_win_count", W'(win_cnt), W'(1152));
        chk("t4_fd_count", W'(fd_cnt), W'(2));
        chk("t4_last_e00", W'(last_fd_e00), W'(1667));

        // Reset mid-frame, then a clean frame.
        start_frame();
        send_pixels(300, 0, 0, 0, 30);
        pix_valid = 1'b0; win_ready = 1'b0; reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t5_reset_win_valid", W'(win_valid), W'(0));
        chk("t5_reset_frame_done", W'(frame_done), W'(0));
        chk("t5_reset_win_row", W'(win_row), W'(0));
        exp_q.delete();
        m_row = 0; m_col = 0; stalled_prev = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        start_frame();
        send_pixels(N * N, 0, 0, 0, 0);
        drain();
        chk("t5_first_latency", W'(first_acc), W'(117));
        chk("t5_win_count", W'(win_cnt), W'(576));
        chk("t5_last_e00", W'(last_fd_e00), W'(667));

        // Negative pixels keep their bit pattern.
        start_frame();
        send_pixels(N * N, 0, 1, 0, 25);
        drain();
        chk("t6_first_e00", W'(first_e00), W'(16'hFFFF));
        chk("t6_last_e00", W'(last_fd_e00), W'(16'hFD64));
        chk("t6_win_count", W'(win_cnt), W'(576));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
Streaming sliding-window generator that produces the flattened KERNEL_SIZE x KERNEL_SIZE pixel vector consumed by convolver_complex on its pixel_in bus. Accepts one raster-order pixel per handshake, keeps the previous KERNEL_SIZE-1 image rows in line buffers, and emits one window per valid output position, "valid" padding only (no zero padding). Sits between the image source (memory reader / previous layer) and the convolver.

Parameters:
DATA_WIDTH, 16, signed fixed-point pixel width (FRAC_BIT format passes through untouched)
KERNEL_SIZE, 5, window side length K
IMAGE_SIZE, 28, square image side N; N >= K

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high
pix_valid  input  1  pix_data holds a valid pixel
pix_ready  output  1  block can accept a pixel this cycle
pix_data  input  DATA_WIDTH  signed pixel, raster order (row-major, top-left first)
win_valid  output  1  win_data holds a complete window
win_ready  input  1  downstream accepts window this cycle
win_data  output  K*K*DATA_WIDTH  flattened window; element (r,c) at [(r*K+c)*DATA_WIDTH +: DATA_WIDTH], r=0 top row, c=0 leftmost column
win_row  output  clog2(N)  output-map row of window (top-left pixel row)
win_col  output  clog2(N)  output-map column of window
frame_done  output  1  high together with win_valid for the last window of a frame (win_row=win_col=N-K)

Behaviour:
- Clock/reset: single clock clk; reset synchronous active-high. On a clk edge with reset=1: row/col counters=0, win_valid=0, win_data=0, win_row=0, win_col=0, frame_done=0. Line buffer / window register contents need not be cleared; validity is gated by counters only.
- Handshake: pixel accepted on an edge where pix_valid && pix_ready. pix_ready = !win_valid || win_ready (combinational; low only while a window is stalled). Window consumed on an edge where win_valid && win_ready.
- Counters: row (0..N-1), col (0..N-1) index the next accepted pixel. Each accept: col++; at col=N-1 wrap col->0, row++; at (N-1,N-1) wrap both to 0 (next frame starts immediately, no idle cycle required).
- Storage: K-1 line buffers of N entries each (register arrays or inferred RAM, read/write same address = col). On accept at column col, the column vector entering the window is: row K-1 = pix_data, row K-2 = linebuf[0][col], ..., row 0 = linebuf[K-2][col]. Line buffers then shift: linebuf[0][col] <= pix_data, linebuf[i][col] <= old linebuf[i-1][col].
- Window register: K x K; on each accept all columns shift left by one (column 0 dropped), the new column enters at c=K-1.
- Emission: if the accepted pixel is at (row>=K-1, col>=K-1), at the next edge win_valid=1, win_data = window whose bottom-right is that pixel, win_row=row-(K-1), win_col=col-(K-1), frame_done=(row==N-1 && col==N-1). Latency = 1 cycle after accept.
- If a pixel is accepted that does not complete a window while the current window is consumed, win_valid drops to 0 next edge. If neither accept nor consume, outputs hold.
- Stall: while win_valid && !win_ready, win_data/win_row/win_col/frame_done stay stable and no pixel is accepted.
- Windows spanning a row boundary are never emitted (gated by col>=K-1); stale columns from the previous row are fully shifted out by then.
- Count per frame: (N-K+1)^2 windows (576 at defaults); first window after the (K-1)*N+K-th accept (117 at defaults).
- Reset mid-frame: pending window dropped; the next accepted pixel is treated as (0,0) of a new frame.
- Values are copied bit-exact; no arithmetic, saturation or sign change.

Test Plan:
- Ramp frame, pix=row*28+col, pix_valid=1, win_ready=1 -> first win_valid 1 cycle after 117th accept, element (r,c)=r*28+c, win_row=win_col=0; 576 windows total, last has element(0,0)=23*28+23=667, frame_done=1 only on it.
- Same ramp, win_ready toggled pseudo-randomly -> pix_ready low exactly while win_valid&&!win_ready, win_data stable when stalled, identical 576-window sequence.
- Random gaps on pix_valid (~50%) -> identical window contents/order to gapless run; no window emitted for col<4 or row<4.
- Two frames back-to-back (frame 2 = ramp+1000) -> frame 2 windows contain only frame-2 values, win_row/win_col restart at 0, two frame_done pulses.
- Reset asserted after 300 accepts, then fresh ramp -> win_valid=0 the cycle after reset, next frame output matches the single-frame golden exactly.
- Negative pixels (pix=-(row*28+col)-1, e.g. 16'hFFFF at (0,0)) -> emitted elements bit-identical, sign preserved.
